// File: rtl/multicycle_control.sv
// Main controller for the multi-cycle datapath. Sequences fetch, decode,
// execute, memory and writeback over the shared memory/ALU. It stalls on
// mem_ready and counts the instructions that it retires.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       OP,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALU_OP,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_R_WB      = 4'd4,
    S_EXEC_ADDI = 4'd5,
    S_EXEC_SUBI = 4'd6,
    S_I_WB      = 4'd7,
    S_MEM_ADDR  = 4'd8,
    S_MEM_RD    = 4'd9,
    S_LD_WB     = 4'd10,
    S_MEM_WR    = 4'd11,
    S_BRANCH    = 4'd12,
    S_JUMP      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001100;
  localparam logic [5:0] OP_SUBI = 6'b001101;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b010011;
  localparam logic [5:0] OP_J    = 6'b011100;

  state_t           state_r;
  state_t           next_s;
  ctrl_t            ctrl_r;
  logic [CNT_W-1:0] retired_r;
  logic             retire_s;
  logic             legal_s;
  logic             fetch_ready_s;
  state_t           boundary_s;

  // Moore control word for a given state; FETCH's ir_write/pc_write are
  // qualified by mem_ready outside this table.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    begin c.alu_src_b = 2'b11; end
      S_EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_EXEC_ADDI: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_EXEC_SUBI: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b01; end
      S_I_WB:      begin c.reg_write = 1'b1; end
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD:    begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_LD_WB:     begin c.reg_write = 1'b1; c.mem2reg = 1'b1; end
      S_MEM_WR:    begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_BRANCH:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                         c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      S_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  // Opcode legality check used for the illegal_op pulse in DECODE.
  always_comb begin
    case (OP)
      OP_R, OP_ADDI, OP_SUBI, OP_SW, OP_LW, OP_BEQ, OP_J: legal_s = 1'b1;
      default:                                            legal_s = 1'b0;
    endcase
  end

  // Next-state selection and retirement strobe.
  always_comb begin
    next_s     = S_IDLE;
    retire_s   = 1'b0;
    boundary_s = en ? S_FETCH : S_IDLE;
    case (state_r)
      S_IDLE:      next_s = en ? S_FETCH : S_IDLE;
      S_FETCH:     next_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OP)
          OP_R:          next_s = S_EXEC_R;
          OP_ADDI:       next_s = S_EXEC_ADDI;
          OP_SUBI:       next_s = S_EXEC_SUBI;
          OP_SW, OP_LW:  next_s = S_MEM_ADDR;
          OP_BEQ:        next_s = S_BRANCH;
          OP_J:          next_s = S_JUMP;
          default:       next_s = boundary_s;
        endcase
      end
      S_EXEC_R:    next_s = S_R_WB;
      S_EXEC_ADDI: next_s = S_I_WB;
      S_EXEC_SUBI: next_s = S_I_WB;
      S_MEM_ADDR: begin
        if (OP == OP_LW) begin
          next_s = S_MEM_RD;
        end else if (OP == OP_SW) begin
          next_s = S_MEM_WR;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_MEM_RD:    next_s = mem_ready ? S_LD_WB : S_MEM_RD;
      S_MEM_WR: begin
        if (mem_ready) begin
          retire_s = 1'b1;
          next_s   = boundary_s;
        end else begin
          next_s = S_MEM_WR;
        end
      end
      S_R_WB, S_I_WB, S_LD_WB, S_BRANCH, S_JUMP: begin
        retire_s = 1'b1;
        next_s   = boundary_s;
      end
      default:     next_s = S_IDLE;
    endcase
  end

  // State, registered control word and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      ctrl_r    <= '0;
      retired_r <= '0;
    end else begin
      state_r <= next_s;
      ctrl_r  <= decode_ctrl(next_s);
      if (retire_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign fetch_ready_s = (state_r == S_FETCH) && mem_ready;

  assign pc_write      = ctrl_r.pc_write | fetch_ready_s;
  assign ir_write      = ctrl_r.ir_write | fetch_ready_s;
  assign pc_write_cond = ctrl_r.pc_write_cond;
  assign pc_source     = ctrl_r.pc_source;
  assign i_or_d        = ctrl_r.i_or_d;
  assign mem_read      = ctrl_r.mem_read;
  assign mem_write     = ctrl_r.mem_write;
  assign mem2reg       = ctrl_r.mem2reg;
  assign reg_write     = ctrl_r.reg_write;
  assign reg_dst       = ctrl_r.reg_dst;
  assign alu_src_a     = ctrl_r.alu_src_a;
  assign alu_src_b     = ctrl_r.alu_src_b;
  assign ALU_OP        = ctrl_r.alu_op;
  assign illegal_op    = (state_r == S_DECODE) && !legal_s;
  assign retired       = retired_r;
  assign state         = state_r;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main controller for the multi-cycle version of the processor. It replaces the single-cycle opcode decoder.
- Sequences the shared datapath (single memory, single ALU, IR, PC, register file) through fetch, decode, execute, memory and writeback.
- Supports the existing ISA: R-type 000000, addi 001100, subi 001101, sw 010000, lw 010001, beq 010011, j 011100.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; sampled in IDLE and at instruction boundaries
- OP  in  6  opcode field from IR; stable from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ir_write  out  1  IR load
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem2reg  out  1  writeback source: 1 MDR
- reg_write  out  1  register file write
- reg_dst  out  1  1 rd, 0 rt
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALU_OP  out  2  00 add, 01 sub, 10 funct
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- retired  out  CNT_W  retired-instruction count
- state  out  4  current state, for debug

Behaviour:
- State register: 4-bit, async reset to IDLE. retired resets to 0.
- In IDLE every control output is 0, including ALU_OP=00 and illegal_op=0. These are the reset values.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0.
  - en=1 -> FETCH; else stay.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALU_OP=00, pc_source=00.
  - ir_write and pc_write = mem_ready (the only Mealy-qualified outputs).
  - mem_ready=0 -> stay; mem_ready=1 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ALU_OP=00 (branch target into ALUOut). Dispatch on OP:
  - R -> EXEC_R
  - addi -> EXEC_ADDI
  - subi -> EXEC_SUBI
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - j -> JUMP
  - other -> illegal_op=1 this cycle, then FETCH if en else IDLE; not retired
- EXEC_R: alu_src_a=1, alu_src_b=00, ALU_OP=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem2reg=0 -> boundary.
- EXEC_ADDI: alu_src_a=1, alu_src_b=10, ALU_OP=00 -> I_WB.
- EXEC_SUBI: same as EXEC_ADDI but ALU_OP=01 -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem2reg=0 -> boundary.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALU_OP=00.
  - lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1.
  - Stay until mem_ready=1, then LD_WB.
- LD_WB: reg_write=1, reg_dst=0, mem2reg=1 -> boundary.
- MEM_WR: mem_write=1, i_or_d=1.
  - Stay until mem_ready=1, then boundary.
  - mem_write stays high for every stall cycle.
- BRANCH: alu_src_a=1, alu_src_b=00, ALU_OP=01, pc_write_cond=1, pc_source=01 -> boundary.
- JUMP: pc_write=1, pc_source=10 -> boundary.
- Boundary:
  - retired += 1 on the exiting edge; wraps at 2^CNT_W.
  - Next state is FETCH if en=1, else IDLE.
  - en is ignored mid-instruction.
- Latency with mem_ready tied high:
  - R, addi, subi, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in all non-memory states.
- rst_n low in any state, including a stall: immediate return to IDLE, outputs 0, retired=0.
  - An interrupted instruction is not retired.
- Unused state encodings -> IDLE on the next edge; outputs 0 in those states.

Test Plan:
- Reset then en=1, OP=000000, mem_ready=1 -> state IDLE, FETCH, DECODE, EXEC_R, R_WB; R_WB shows reg_write=1, reg_dst=1; retired 0->1 on the edge leaving R_WB.
- OP=010001 with mem_ready=0 for 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held for 4 cycles; LD_WB shows mem2reg=1, reg_write=1; total 8 cycles from FETCH.
- OP=001101 -> EXEC_SUBI shows ALU_OP=01, alu_src_b=10; OP=001100 -> EXEC_ADDI shows ALU_OP=00; both pass through I_WB with reg_dst=0.
- FETCH with mem_ready low 2 cycles -> ir_write=pc_write=0 for those cycles, 1 in the ready cycle only; beq -> BRANCH shows pc_write_cond=1, pc_source=01; j -> JUMP shows pc_write=1, pc_source=10.
- OP=111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
- rst_n dropped asynchronously mid-MEM_WR stall -> outputs 0 before the next edge, retired=0; en=0 at a boundary -> IDLE, stays until en=1; CNT_W=2 with 5 retired instructions -> retired=1.
